// File: rtl/vex_issue_ctrl_pkg.sv
// Shared vector-lane package: issue FSM state encoding and the default
// multiplier latency, also used by the vex execution lane.
package vex_issue_ctrl_pkg;

  // Extra cycles a multiply takes over a single-cycle op.
  localparam int unsigned VEX_MUL_LATENCY = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PERM_WAIT = 2'd1,
    PERM_WB   = 2'd2
  } vex_issue_state_e;

endpackage

// File: rtl/vex_issue_ctrl_wb_reserve.sv
// vex_wb_reserve: writeback reservation shift register with a parallel tag
// array for the vex issue controller.
//   clk, rst           : clock, asynchronous active-low reset
//   ins_en/ins_mul/tag : insert a reservation (slot MUL_LATENCY when mul,
//                        slot 0 otherwise, in the post-shift view)
//   q_src1..3, q_used  : source tags queried against pending reservations
//   slot0_busy         : post-shift slot 0 is taken (non-mul collision)
//   any_busy           : any pending reservation in the post-shift view
//   src_hit            : per-source tag match against pending reservations
//   wb_valid, wb_tag   : stored slot 0, i.e. the writeback of this cycle
module vex_wb_reserve
  import vex_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = VEX_MUL_LATENCY,
  parameter int unsigned REG_BITS    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ins_en,
  input  logic                ins_mul,
  input  logic [REG_BITS-1:0] ins_tag,
  input  logic [REG_BITS-1:0] q_src1,
  input  logic [REG_BITS-1:0] q_src2,
  input  logic [REG_BITS-1:0] q_src3,
  input  logic [2:0]          q_used,
  output logic                slot0_busy,
  output logic                any_busy,
  output logic [2:0]          src_hit,
  output logic                wb_valid,
  output logic [REG_BITS-1:0] wb_tag
);

  localparam int unsigned TW = (MUL_LATENCY + 1) * REG_BITS;

  // Stored index i+1 is post-shift slot i of the current cycle; stored
  // index 0 has already shifted out and is the writeback happening now.
  logic [MUL_LATENCY:0] res_q, res_d;
  logic [TW-1:0]        tag_q, tag_d;
  logic [MUL_LATENCY:1] hit1, hit2, hit3;

  always_comb begin
    res_d = {1'b0, res_q[MUL_LATENCY:1]};
    tag_d = {{REG_BITS{1'b0}}, tag_q[TW-1:REG_BITS]};
    // Insertion overrides the shifted-in value; the target slot was
    // already checked free against the post-shift view.
    if (ins_en) begin
      if (ins_mul) begin
        res_d[MUL_LATENCY]                      = 1'b1;
        tag_d[MUL_LATENCY*REG_BITS +: REG_BITS] = ins_tag;
      end else begin
        res_d[0]              = 1'b1;
        tag_d[REG_BITS-1:0]   = ins_tag;
      end
    end
  end

  for (genvar g = 1; g <= MUL_LATENCY; g++) begin : g_match
    always_comb begin
      hit1[g] = res_q[g] && (tag_q[g*REG_BITS +: REG_BITS] == q_src1);
      hit2[g] = res_q[g] && (tag_q[g*REG_BITS +: REG_BITS] == q_src2);
      hit3[g] = res_q[g] && (tag_q[g*REG_BITS +: REG_BITS] == q_src3);
    end
  end

  always_comb begin
    slot0_busy = res_q[1];
    any_busy   = |res_q[MUL_LATENCY:1];
    src_hit    = {q_used[2] && (|hit3), q_used[1] && (|hit2), q_used[0] && (|hit1)};
    wb_valid   = res_q[0];
    wb_tag     = tag_q[REG_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      tag_q <= '0;
    end else begin
      res_q <= res_d;
      tag_q <= tag_d;
    end
  end

endmodule

// File: rtl/vex_issue_ctrl.sv
// vex_issue_ctrl: issue controller in front of the vector lane execution
// stage. Decides per cycle whether a decoded micro-op may enter the lane,
// accounting for multiplier latency, writeback slot collisions, RAW/WAW
// hazards (in-flight results and a pending load) and the permutation
// handshake; drives the issue strobe and a predicted writeback strobe/tag.
//   clk, rst                    : clock, asynchronous active-low reset
//   in_valid/in_ready           : upstream micro-op handshake
//   in_dest, in_src1..3         : register tags; in_src_used bit0 = src1
//   in_mul, in_perm             : op class
//   load_pending, load_dest     : outstanding vector load
//   perm_done                   : permutation result pulse
//   issue_valid, issue_mul      : issue strobe to the lane
//   wb_valid, wb_dest           : predicted writeback this cycle
//   busy                        : reservations pending or FSM not in RUN
module vex_issue_ctrl
  import vex_issue_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = VEX_MUL_LATENCY,
  parameter int unsigned REG_BITS    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [REG_BITS-1:0] in_dest,
  input  logic [REG_BITS-1:0] in_src1,
  input  logic [REG_BITS-1:0] in_src2,
  input  logic [REG_BITS-1:0] in_src3,
  input  logic [2:0]          in_src_used,
  input  logic                in_mul,
  input  logic                in_perm,
  input  logic                load_pending,
  input  logic [REG_BITS-1:0] load_dest,
  input  logic                perm_done,
  output logic                issue_valid,
  output logic                issue_mul,
  output logic                wb_valid,
  output logic [REG_BITS-1:0] wb_dest,
  output logic                busy
);

  vex_issue_state_e    state_q, state_d;
  logic [REG_BITS-1:0] perm_dest_q, perm_dest_d;

  logic                ins_en;
  logic                slot0_busy;
  logic                any_busy;
  logic [2:0]          src_hit;
  logic                res_wb_valid;
  logic [REG_BITS-1:0] res_wb_tag;
  logic                load_raw;
  logic                load_waw;
  logic                collision;

  vex_wb_reserve #(
    .MUL_LATENCY(MUL_LATENCY),
    .REG_BITS   (REG_BITS)
  ) u_reserve (
    .clk       (clk),
    .rst       (rst),
    .ins_en    (ins_en),
    .ins_mul   (in_mul),
    .ins_tag   (in_dest),
    .q_src1    (in_src1),
    .q_src2    (in_src2),
    .q_src3    (in_src3),
    .q_used    (in_src_used),
    .slot0_busy(slot0_busy),
    .any_busy  (any_busy),
    .src_hit   (src_hit),
    .wb_valid  (res_wb_valid),
    .wb_tag    (res_wb_tag)
  );

  always_comb begin
    state_d     = state_q;
    perm_dest_d = perm_dest_q;

    load_raw  = load_pending &&
                ((in_src_used[0] && (in_src1 == load_dest)) ||
                 (in_src_used[1] && (in_src2 == load_dest)) ||
                 (in_src_used[2] && (in_src3 == load_dest)));
    load_waw  = load_pending && (in_dest == load_dest);
    // A mul lands in the top slot, which is always empty after the shift.
    collision = !in_mul && slot0_busy;

    in_ready    = (state_q == RUN) && !collision && !(|src_hit) &&
                  !load_raw && !load_waw && (!in_perm || !any_busy);
    issue_valid = in_valid && in_ready;
    issue_mul   = issue_valid && in_mul;
    // Perm results return through PERM_WB, not through a reservation.
    ins_en      = issue_valid && !in_perm;

    unique case (state_q)
      RUN: begin
        if (issue_valid && in_perm) begin
          state_d     = PERM_WAIT;
          perm_dest_d = in_dest;
        end
      end
      PERM_WAIT: if (perm_done) state_d = PERM_WB;
      PERM_WB:   state_d = RUN;
      default:   state_d = RUN;
    endcase

    wb_valid = res_wb_valid || (state_q == PERM_WB);
    wb_dest  = (state_q == PERM_WB) ? perm_dest_q : res_wb_tag;
    busy     = any_busy || (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      perm_dest_q <= '0;
    end else begin
      state_q     <= state_d;
      perm_dest_q <= perm_dest_d;
    end
  end

endmodule

// File: tb/tb_vex_issue_ctrl.sv
module tb_vex_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_dest, in_src1, in_src2, in_src3;
  logic [2:0] in_src_used;
  logic       in_mul, in_perm;
  logic       load_pending;
  logic [4:0] load_dest;
  logic       perm_done;
  logic       issue_valid, issue_mul;
  logic       wb_valid;
  logic [4:0] wb_dest;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  vex_issue_ctrl #(
    .MUL_LATENCY(3),
    .REG_BITS   (5)
  ) dut (
    .clk         (clk),
    .rst         (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_src1     (in_src1),
    .in_src2     (in_src2),
    .in_src3     (in_src3),
    .in_src_used (in_src_used),
    .in_mul      (in_mul),
    .in_perm     (in_perm),
    .load_pending(load_pending),
    .load_dest   (load_dest),
    .perm_done   (perm_done),
    .issue_valid (issue_valid),
    .issue_mul   (issue_mul),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, v;
    logic [4:0] dest, s1, s2, s3;
    logic [2:0] used;
    logic       mul, perm, lp;
    logic [4:0] ld;
    logic       pd;
    logic       e_rdy, e_iss, e_wbv;
    logic [4:0] e_wbd;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [4:0] dest,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] s3,
                     input logic [2:0] used, input logic mul, input logic perm,
                     input logic lp, input logic [4:0] ld, input logic pd,
                     input logic e_rdy, input logic e_iss, input logic e_wbv,
                     input logic [4:0] e_wbd, input logic e_busy);
    vec_t x;
    x.rst_n = r; x.v = v; x.dest = dest; x.s1 = s1; x.s2 = s2; x.s3 = s3;
    x.used = used; x.mul = mul; x.perm = perm; x.lp = lp; x.ld = ld; x.pd = pd;
    x.e_rdy = e_rdy; x.e_iss = e_iss; x.e_wbv = e_wbv; x.e_wbd = e_wbd;
    x.e_busy = e_busy;
    vecs.push_back(x);
  endtask

  task automatic idle(input logic pd, input logic e_rdy, input logic e_wbv,
                      input logic [4:0] e_wbd, input logic e_busy);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, pd, e_rdy, 0, e_wbv, e_wbd, e_busy);
  endtask

  task automatic chk(input string nm, input int idx, input logic [4:0] act,
                     input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0d expected=%0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    in_valid = 0; in_dest = 0; in_src1 = 0; in_src2 = 0; in_src3 = 0;
    in_src_used = 0; in_mul = 0; in_perm = 0; load_pending = 0;
    load_dest = 0; perm_done = 0;
  endtask

  initial begin
    // Back-to-back non-mul, dests 1..4
    add(1,1,1,0,0,0,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,1,2,0,0,0,0,0,0,0,0,0, 1,1,1,1,0);
    add(1,1,3,0,0,0,0,0,0,0,0,0, 1,1,1,2,0);
    add(1,1,4,0,0,0,0,0,0,0,0,0, 1,1,1,3,0);
    idle(0, 1,1,4,0);
    idle(0, 1,0,0,0);
    // Mul dest 5 at t0, non-mul dest 6 at t3 collides, issues t4
    add(1,1,5,0,0,0,0,1,0,0,0,0, 1,1,0,0,0);
    idle(0, 1,0,0,1);
    idle(0, 1,0,0,1);
    add(1,1,6,0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    add(1,1,6,0,0,0,0,0,0,0,0,0, 1,1,1,5,0);
    idle(0, 1,1,6,0);
    idle(0, 1,0,0,0);
    // RAW on mul result: src2 = 7 stalls t1..t3, issues t4
    add(1,1,7,0,0,0,0,1,0,0,0,0, 1,1,0,0,0);
    add(1,1,8,0,7,0,2,0,0,0,0,0, 0,0,0,0,1);
    add(1,1,8,0,7,0,2,0,0,0,0,0, 0,0,0,0,1);
    add(1,1,8,0,7,0,2,0,0,0,0,0, 0,0,0,0,1);
    add(1,1,8,0,7,0,2,0,0,0,0,0, 1,1,1,7,0);
    idle(0, 1,1,8,0);
    // Load hazards
    add(1,1,11,9,0,0,1,0,0,1,9,0, 0,0,0,0,0);
    add(1,1,11,9,0,0,1,0,0,1,9,0, 0,0,0,0,0);
    add(1,1,11,9,0,0,1,0,0,0,9,0, 1,1,0,0,0);
    add(1,1,9,0,0,0,0,0,0,1,9,0, 0,0,1,11,0);
    add(1,1,10,10,10,0,3,0,0,1,9,0, 1,1,0,0,0);
    idle(0, 1,1,10,0);
    // Permutation behind an in-flight mul
    add(1,1,12,0,0,0,0,1,0,0,0,0, 1,1,0,0,0);
    add(1,1,13,0,0,0,0,0,1,0,0,0, 0,0,0,0,1);
    add(1,1,13,0,0,0,0,0,1,0,0,0, 0,0,0,0,1);
    add(1,1,13,0,0,0,0,0,1,0,0,0, 0,0,0,0,1);
    add(1,1,13,0,0,0,0,0,1,0,0,0, 1,1,1,12,0);
    for (int k = 0; k < 5; k++) add(1,1,14,0,0,0,0,0,0,0,0,0, 0,0,0,0,1);
    add(1,1,14,0,0,0,0,0,0,0,0,1, 0,0,0,0,1);
    add(1,1,14,0,0,0,0,0,0,0,0,0, 0,0,1,13,1);
    add(1,1,14,0,0,0,0,0,0,0,0,0, 1,1,0,0,0);
    add(1,1,15,0,0,0,0,0,0,0,0,0, 1,1,1,14,0);
    idle(0, 1,1,15,0);
    idle(1, 1,0,0,0);
    idle(0, 1,0,0,0);
    // Reset two cycles after a mul issue
    add(1,1,16,0,0,0,0,1,0,0,0,0, 1,1,0,0,0);
    idle(0, 1,0,0,1);
    add(0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0);
    idle(0, 1,0,0,0);
    idle(0, 1,0,0,0);
    add(1,1,17,0,0,0,0,0,0,0,0,0, 1,1,0,0,0);
    idle(0, 1,1,17,0);
    // Mul -> mul back to back
    add(1,1,18,0,0,0,0,1,0,0,0,0, 1,1,0,0,0);
    add(1,1,19,0,0,0,0,1,0,0,0,0, 1,1,0,0,1);
    idle(0, 1,0,0,1);
    idle(0, 0,0,0,1);
    idle(0, 0,1,18,1);
    idle(0, 1,1,19,0);
    idle(0, 1,0,0,0);

    rst_n = 1'b0;
    drive_idle();
    #1;
    chk("reset_wb_valid", -1, 5'(wb_valid), 0);
    chk("reset_wb_dest",  -1, wb_dest, 0);
    chk("reset_busy",     -1, 5'(busy), 0);
    chk("reset_in_ready", -1, 5'(in_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n        = vecs[i].rst_n;
      in_valid     = vecs[i].v;
      in_dest      = vecs[i].dest;
      in_src1      = vecs[i].s1;
      in_src2      = vecs[i].s2;
      in_src3      = vecs[i].s3;
      in_src_used  = vecs[i].used;
      in_mul       = vecs[i].mul;
      in_perm      = vecs[i].perm;
      load_pending = vecs[i].lp;
      load_dest    = vecs[i].ld;
      perm_done    = vecs[i].pd;
      #1;
      chk("in_ready",    i, 5'(in_ready),    5'(vecs[i].e_rdy));
      chk("issue_valid", i, 5'(issue_valid), 5'(vecs[i].e_iss));
      chk("issue_mul",   i, 5'(issue_mul),   5'(vecs[i].e_iss & vecs[i].mul));
      chk("wb_valid",    i, 5'(wb_valid),    5'(vecs[i].e_wbv));
      chk("busy",        i, 5'(busy),        5'(vecs[i].e_busy));
      if (vecs[i].e_wbv) chk("wb_dest", i, wb_dest, vecs[i].e_wbd);
    end

    // Asynchronous reset in PERM_WAIT, away from any clock edge
    @(negedge clk);
    drive_idle();
    in_valid = 1; in_perm = 1; in_dest = 20;
    #1;
    chk("perm_issue", 100, 5'(issue_valid), 1);
    @(negedge clk);
    drive_idle();
    #1;
    chk("perm_wait_busy",  101, 5'(busy), 1);
    chk("perm_wait_ready", 101, 5'(in_ready), 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_busy",  102, 5'(busy), 0);
    chk("async_rst_wb",    102, 5'(wb_valid), 0);
    chk("async_rst_ready", 102, 5'(in_ready), 1);
    @(negedge clk);
    rst_n = 1; perm_done = 1;
    #1;
    chk("pd_in_run_wb", 103, 5'(wb_valid), 0);
    @(negedge clk);
    perm_done = 0;
    #1;
    chk("pd_in_run_wb2",   104, 5'(wb_valid), 0);
    chk("pd_in_run_busy",  104, 5'(busy), 0);
    chk("pd_in_run_ready", 104, 5'(in_ready), 1);
    @(negedge clk);
    in_valid = 1; in_dest = 21;
    #1;
    chk("post_rst_issue", 105, 5'(issue_valid), 1);
    @(negedge clk);
    drive_idle();
    #1;
    chk("post_rst_wb",      106, 5'(wb_valid), 1);
    chk("post_rst_wb_dest", 106, wb_dest, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
